jb_orx_ant_sched: RTL and testbench

Observation-receiver (ORX) antenna scheduler for the radio hardware-control plane. It steps the shared ORX path round-robin across the enabled antennas. For each antenna it:
- drives `orx_ant_sel`,
- waits the programmed switch-settle delay,
- requests one capture from the DPD/calibration capture engine, then moves on when that capture is acknowledged or times out.

It sits between the hardware-control register block and the ORX RF switch / capture logic. A software override bypasses the sequence.

---
 rtl/jb_orx_ant_sched.sv | 139 +++++++++++++
 tb/tb_jb_orx_ant_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_orx_ant_sched.sv
// ORX antenna scheduler: walks the enabled antennas round-robin, settles the RF
// switch on each one and requests a single capture before moving on.
module jb_orx_ant_sched #(
    parameter int NUM_ANT = 8,
    parameter int ANT_W   = 3,
    parameter int DLY_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_ANT-1:0] ant_mask,
    input  logic [DLY_W-1:0]   settle_dly,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               rf_switch_override,
    input  logic [ANT_W-1:0]   override_ant,
    input  logic               cap_ack,
    input  logic               err_clr,
    output logic [ANT_W-1:0]   orx_ant_sel,
    output logic               cap_req,
    output logic [ANT_W-1:0]   cap_ant,
    output logic               busy,
    output logic               round_done,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_CAPTURE, S_NEXT
    } state_t;

    state_t             state, state_nxt;
    logic [ANT_W-1:0]   last_ant;
    logic [NUM_ANT-1:0] mask_q;
    logic [DLY_W-1:0]   settle_cnt;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [ANT_W-1:0]   hi_ant, lo_ant, sel_ant;
    logic               hi_found, more_above;
    logic               mask_any, run_ok, timeout_hit;

    // Next antenna is the lowest set bit above last_ant, else the lowest set bit
    // overall; more_above tells NEXT whether the sampled round still has work.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        hi_ant     = '0;
        lo_ant     = '0;
        hi_found   = 1'b0;
        more_above = 1'b0;
        for (int j = NUM_ANT - 1; j >= 0; j--) begin
            if (ant_mask[j]) begin
                if (ANT_W'(j) > last_ant) begin
                    hi_ant   = ANT_W'(j);
                    hi_found = 1'b1;
                end else begin
                    lo_ant = ANT_W'(j);
                end
            end
            if (mask_q[j] && (ANT_W'(j) > last_ant)) more_above = 1'b1;
        end
        sel_ant = hi_found ? hi_ant : lo_ant;
    end

    assign mask_any    = |ant_mask;
    assign run_ok      = enable && mask_any && !rf_switch_override;
    assign timeout_hit = (state == S_CAPTURE) && (dwell_cycles != '0) && !cap_ack
                         && (dwell_cnt == dwell_cycles - DWELL_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (run_ok) state_nxt = S_SELECT;
            S_SELECT:  state_nxt = mask_any ? S_SETTLE : S_IDLE;
            S_SETTLE: begin
                if (!enable)                 state_nxt = S_IDLE;
                else if (settle_cnt == '0)   state_nxt = S_CAPTURE;
            end
            S_CAPTURE: if (cap_ack || timeout_hit) state_nxt = S_NEXT;
            S_NEXT:    state_nxt = run_ok ? S_SELECT : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (rf_switch_override) state_nxt = S_IDLE;
    end

    assign cap_req    = (state == S_CAPTURE);
    assign busy       = (state != S_IDLE);
    assign round_done = (state == S_NEXT) && !more_above;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_ant    <= ANT_W'(NUM_ANT - 1);
            mask_q      <= '0;
            settle_cnt  <= '0;
            dwell_cnt   <= '0;
            orx_ant_sel <= '0;
            cap_ant     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;

            if (timeout_hit)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            if (rf_switch_override) begin
                orx_ant_sel <= override_ant;
                settle_cnt  <= '0;
                dwell_cnt   <= '0;
            end else begin
                dwell_cnt <= '0;
                case (state)
                    S_SELECT: begin
                        if (mask_any) begin
                            orx_ant_sel <= sel_ant;
                            cap_ant     <= sel_ant;
                            last_ant    <= sel_ant;
                            mask_q      <= ant_mask;
                            settle_cnt  <= settle_dly;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt != '0) settle_cnt <= settle_cnt - DLY_W'(1);
                    end
                    S_CAPTURE: begin
                        // Saturate so an untimed capture never wraps the counter.
                        if ((state_nxt == S_CAPTURE) && (dwell_cnt != '1))
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        else if (state_nxt == S_CAPTURE)
                            dwell_cnt <= dwell_cnt;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jb_orx_ant_sched.sv
// Bench for jb_orx_ant_sched: a planner predicts each capture from the rotation
// rules, a monitor pops and checks predictions whenever cap_req rises or falls.
`timescale 1ns/1ps
module tb_jb_orx_ant_sched;

    localparam int NUM_ANT = 8;
    localparam int ANT_W   = 3;
    localparam int DLY_W   = 16;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic [NUM_ANT-1:0] ant_mask = '0;
    logic [DLY_W-1:0]   settle_dly = '0;
    logic [DWELL_W-1:0] dwell_cycles = '0;
    logic               rf_switch_override = 1'b0;
    logic [ANT_W-1:0]   override_ant = '0;
    logic               cap_ack = 1'b0;
    logic               err_clr = 1'b0;
    logic [ANT_W-1:0]   orx_ant_sel;
    logic               cap_req;
    logic [ANT_W-1:0]   cap_ant;
    logic               busy;
    logic               round_done;
    logic               timeout_err;

    jb_orx_ant_sched #(
        .NUM_ANT(NUM_ANT), .ANT_W(ANT_W), .DLY_W(DLY_W), .DWELL_W(DWELL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ant_mask(ant_mask),
        .settle_dly(settle_dly), .dwell_cycles(dwell_cycles),
        .rf_switch_override(rf_switch_override), .override_ant(override_ant),
        .cap_ack(cap_ack), .err_clr(err_clr), .orx_ant_sel(orx_ant_sel),
        .cap_req(cap_req), .cap_ant(cap_ant), .busy(busy),
        .round_done(round_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ant;
        int settle;
        int len;
        int gap;
        bit lat;
        bit rnd;
        bit chk_end;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_last, m_sel;
    int   rise_cnt = 0;
    int   ack_dly = 1000;
    int   clr_at = 0;
    bit   clr_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_next(input logic [NUM_ANT-1:0] m, input int last);
        for (int i = 1; i <= NUM_ANT; i++)
            if (m[(last + i) % NUM_ANT]) return (last + i) % NUM_ANT;
        return last;
    endfunction

    function automatic int top_bit(input logic [NUM_ANT-1:0] m);
        int t = -1;
        for (int i = 0; i < NUM_ANT; i++) if (m[i]) t = i;
        return t;
    endfunction

    // Predicts k back-to-back captures: request length, rise-to-rise period and
    // select-to-request latency all follow from the settle/ack/dwell settings.
    task automatic plan(input logic [NUM_ANT-1:0] m, input int settle, input int ackd,
                        input int dwell, input int k, input bit chk_end);
        exp_t r;
        int   prev_len = 0;
        for (int i = 0; i < k; i++) begin
            r.ant     = model_next(m, m_last);
            r.settle  = settle;
            r.len     = (dwell != 0 && ackd + 1 > dwell) ? dwell : ackd + 1;
            r.gap     = (i == 0) ? 0 : prev_len + settle + 3;
            r.lat     = (r.ant != m_sel);
            r.rnd     = (r.ant == top_bit(m));
            r.chk_end = chk_end;
            prev_len  = r.len;
            m_last    = r.ant;
            m_sel     = r.ant;
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rise_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rise_count", rise_cnt, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || cap_req) && n < 3000);
        check("busy_after_stop", busy, 0);
    endtask

    // Runs k captures then drops enable during the last CAPTURE.
    task automatic run_seq(input logic [NUM_ANT-1:0] m, input int settle, input int ackd,
                           input int dwell, input int k);
        int base;
        ant_mask     = m;
        settle_dly   = DLY_W'(settle);
        dwell_cycles = DWELL_W'(dwell);
        ack_dly      = ackd;
        plan(m, settle, ackd, dwell, k, 1'b1);
        base = rise_cnt;
        enable = 1'b1;
        rf_switch_override = 1'b0;
        wait_rises(base + k);
        enable = 1'b0;
        wait_idle();
    endtask

    // Capture engine: acks ack_dly cycles after the request, optionally pulses err_clr.
    int resp_cnt = 0;
    always @(negedge clk) begin
        if (cap_req === 1'b1) resp_cnt = resp_cnt + 1;
        else                  resp_cnt = 0;
        cap_ack = (cap_req === 1'b1) && (resp_cnt == ack_dly + 1);
        err_clr = clr_force || ((cap_req === 1'b1) && clr_at != 0 && resp_cnt == clr_at);
    end

    int               cyc = 0, chg_cyc = 0, last_rise = 0, hi_len = 0;
    logic             prev_req = 1'b0;
    logic [ANT_W-1:0] prev_sel = '0;
    exp_t             cur;
    bit               have_cur = 1'b0, ant_moved = 1'b0;
    bit               fell;

    always @(negedge clk) begin
        cyc++;
        if (orx_ant_sel !== prev_sel) chg_cyc = cyc;
        if (cap_req === 1'b1 && prev_req !== 1'b1) begin
            rise_cnt++;
            check("pending_expectation", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                cur       = exp_q.pop_front();
                have_cur  = 1'b1;
                ant_moved = 1'b0;
                check("cap_ant", cap_ant, cur.ant);
                check("orx_ant_sel", orx_ant_sel, cur.ant);
                if (cur.lat) check("select_to_req", cyc - chg_cyc, cur.settle + 1);
                if (cur.gap != 0) check("req_period", cyc - last_rise, cur.gap);
            end
            last_rise = cyc;
            hi_len    = 0;
        end
        if (cap_req === 1'b1) begin
            hi_len++;
            if (have_cur && cap_ant !== cur.ant) ant_moved = 1'b1;
        end
        fell = (cap_req !== 1'b1) && (prev_req === 1'b1);
        if (fell && have_cur) begin
            if (cur.chk_end) begin
                check("req_len", hi_len, cur.len);
                check("round_done", round_done, cur.rnd);
                check("cap_ant_stable", ant_moved, 0);
            end
            have_cur = 1'b0;
        end
        if (!fell && round_done === 1'b1) check("round_done_stray", round_done, 0);
        prev_req = cap_req;
        prev_sel = orx_ant_sel;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_orx_ant_sel", orx_ant_sel, 0);
        check("rst_cap_ant", cap_ant, 0);
        check("rst_cap_req", cap_req, 0);
        check("rst_busy", busy, 0);
        check("rst_round_done", round_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n  = 1'b1;
        m_last = NUM_ANT - 1;
        m_sel  = 0;
        @(negedge clk);

        run_seq(8'hFF, 4, 2, 0, 9);
        run_seq(8'h85, 0, 1, 0, 4);
        run_seq(8'h10, 2, 0, 0, 3);

        for (int r = 0; r < 6; r++)
            run_seq(NUM_ANT'($urandom_range(1, 255)), $urandom_range(0, 5),
                    $urandom_range(0, 3), 0, $urandom_range(1, 6));

        run_seq(8'h03, 1, 1000, 10, 1);
        check("timeout_err_set", timeout_err, 1);
        clr_force = 1'b1;
        repeat (2) @(negedge clk);
        clr_force = 1'b0;
        repeat (2) @(negedge clk);
        check("timeout_err_cleared", timeout_err, 0);
        run_seq(8'h03, 1, 9, 10, 1);
        check("ack_beats_timeout", timeout_err, 0);
        clr_at = 10;
        run_seq(8'h03, 1, 1000, 10, 1);
        clr_at = 0;
        check("set_beats_clear", timeout_err, 1);

        ant_mask   = 8'h0F;
        settle_dly = 30;
        enable     = 1'b1;
        m_last     = model_next(8'h0F, m_last);
        m_sel      = m_last;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("settle_abort_busy", busy, 0);
        check("settle_abort_req", cap_req, 0);

        ant_mask     = 8'h3C;
        settle_dly   = 30;
        override_ant = 3'd5;
        enable       = 1'b1;
        m_last       = model_next(8'h3C, m_last);
        repeat (6) @(negedge clk);
        rf_switch_override = 1'b1;
        @(negedge clk);
        m_sel = 5;
        check("ovr_orx_ant_sel", orx_ant_sel, 5);
        check("ovr_busy", busy, 0);
        check("ovr_cap_req", cap_req, 0);
        repeat (4) @(negedge clk);
        check("ovr_hold_req", cap_req, 0);
        check("ovr_hold_busy", busy, 0);
        run_seq(8'h3C, 3, 1, 0, 3);

        ant_mask     = 8'h04;
        settle_dly   = 2;
        dwell_cycles = '0;
        ack_dly      = 1000;
        plan(8'h04, 2, 1000, 0, 1, 1'b0);
        enable = 1'b1;
        wait_rises(rise_cnt + 1);
        repeat (2) @(negedge clk);
        check("pre_reset_req", cap_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cap_req", cap_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_orx_ant_sel", orx_ant_sel, 0);
        check("mid_rst_cap_ant", cap_ant, 0);
        check("mid_rst_round_done", round_done, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        enable = 1'b0;
        rst_n  = 1'b1;
        m_last = NUM_ANT - 1;
        m_sel  = 0;
        @(negedge clk);
        run_seq(8'h16, 1, 1, 0, 2);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
